// File: rtl/int_mul.sv
`default_nettype none
// ============================================================================
// Module   : int_mul
// Purpose  : Iterative radix-2 shift-add multiplier for the RV32M path.
//            Multiplies two WIDTH-bit operands with per-operand signedness
//            and returns the full 2*WIDTH-bit product split into low and
//            high words. That covers MUL, MULH, MULHSU and MULHU.
//            It uses the same handshake as int_div: a one-cycle start strobe,
//            and a result held with o_valid high until the next start.
// Ports    : i_clk        rising-edge clock
//            i_rst_n      asynchronous active-low reset
//            i_valid      start strobe (accepted in IDLE or DONE)
//            i_a, i_b     multiplicand / multiplier
//            i_a_signed   i_a is two's complement when 1
//            i_b_signed   i_b is two's complement when 1
//            o_busy       iteration in progress
//            o_valid      result valid (held until next start)
//            o_product_lo product bits [WIDTH-1:0]
//            o_product_hi product bits [2*WIDTH-1:WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module int_mul #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_a_signed,
  input  logic             i_b_signed,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_product_lo,
  output logic [WIDTH-1:0] o_product_hi
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mag_a;
  logic               sign_p;

  // Operand magnitudes at capture time. Negating the most negative value
  // wraps back to itself, and that is also its correct unsigned magnitude.
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  assign neg_a    = i_a_signed & i_a[WIDTH-1];
  assign neg_b    = i_b_signed & i_b[WIDTH-1];
  assign in_mag_a = neg_a ? -i_a : i_a;
  assign in_mag_b = neg_b ? -i_b : i_b;

  // One shift-add step. The upper half is kept one bit wider than an operand
  // so that the carry out of the add is not lost before the right shift.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] mag_p;
  logic [2*WIDTH-1:0] product;

  assign sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_a} : '0);
  assign acc_next = {1'b0, sum, acc[WIDTH-1:1]};
  assign mag_p    = acc_next[2*WIDTH-1:0];
  // A zero magnitude negates to zero, so no special case is needed for
  // sign_p with a zero product.
  assign product  = sign_p ? -mag_p : mag_p;

  logic accept;
  assign accept = i_valid && ((state == IDLE) || (state == DONE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      mag_a        <= '0;
      sign_p       <= 1'b0;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_product_lo <= '0;
      o_product_hi <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= CALC;
            count   <= '0;
            acc     <= {{(WIDTH+1){1'b0}}, in_mag_b};
            mag_a   <= in_mag_a;
            sign_p  <= neg_a ^ neg_b;
            o_busy  <= 1'b1;
            o_valid <= 1'b0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          // The final iteration's value goes straight to the outputs, so the
          // result appears on the same edge that enters DONE.
          if (count == CW'(WIDTH - 1)) begin
            state        <= DONE;
            o_busy       <= 1'b0;
            o_valid      <= 1'b1;
            o_product_lo <= product[WIDTH-1:0];
            o_product_hi <= product[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/int_mul.md
Name: int_mul

Overview:
Iterative radix-2 shift-add integer multiplier for the RV32M path, the multiply counterpart of the team's iterative divider. It takes two 32-bit operands with per-operand signedness and returns the full 64-bit product as low and high words, which covers MUL, MULH, MULHSU and MULHU. Handshake style matches the divider: a single-cycle start strobe, and a result that is held with o_valid high until the next start. It sits in the ALU beside int_div; the ALU selects o_product_lo or o_product_hi.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH. Only 32 is verified.

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  reset, asynchronous, active-low
i_valid  input  1  start strobe; samples operands and sign modes
i_a  input  32  multiplicand
i_b  input  32  multiplier
i_a_signed  input  1  1: i_a is two's complement; 0: i_a is unsigned
i_b_signed  input  1  1: i_b is two's complement; 0: i_b is unsigned
o_busy  output  1  high while state is CALC
o_valid  output  1  high while state is DONE (result valid)
o_product_lo  output  32  product bits [31:0]
o_product_hi  output  32  product bits [63:32]

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, count=0, accumulator=0, o_product_lo=0, o_product_hi=0, o_busy=0, o_valid=0. Asserting reset mid-CALC aborts the operation; no o_valid follows.
- States:
  - IDLE: i_valid goes to CALC, otherwise stay.
  - CALC: count increments each cycle; at count==31 go to DONE.
  - DONE: i_valid goes to CALC, otherwise stay.
  - Illegal encoding goes to IDLE.
- Capture, on the edge where i_valid=1 in IDLE or DONE:
  - neg_a = i_a_signed & i_a[31]; neg_b = i_b_signed & i_b[31].
  - mag_a = neg_a ? -i_a : i_a (32-bit unsigned; 0x80000000 stays 0x80000000).
  - mag_b is formed the same way.
  - accumulator (65 bits) = {33'd0, mag_b}; mag_a is held in a register; sign_p = neg_a ^ neg_b; count=0.
- i_valid while in CALC is ignored. The operation in flight completes and its operands are not replaced.
- CALC iteration, one per cycle:
  - sum = acc[64:32] + (acc[0] ? {1'b0,mag_a} : 0), 33 bits.
  - acc = {sum, acc[31:1]} >> alignment, i.e. the whole 65-bit {sum, acc[31:0]} is shifted right by 1.
  - After 32 iterations acc[63:0] = mag_a*mag_b, exact with no overflow.
- Result: registered on the CALC edge with count==31, using the value computed in that cycle.
  - product = sign_p ? (~mag_p + 1) : mag_p, 64-bit.
  - A zero magnitude product yields 0 regardless of sign_p.
- Latency: the accept edge is T0; iterations run at edges T1..T32; state=DONE and outputs update at T32, so o_valid is high 32 cycles after accept.
- Outputs hold their values in DONE and IDLE. During the next CALC, o_product_lo/hi keep the previous result and o_valid=0.
- Back-to-back: i_valid in the first DONE cycle is accepted, and o_valid drops at that edge.
- Any i_valid asserted in IDLE or DONE re-samples all inputs; the operands need only be stable on the accept edge.

Test Plan:
- Unsigned 7 * 3 (both signed flags 0) -> o_valid high exactly 32 cycles after accept; lo=0x00000015, hi=0x00000000; o_busy high for exactly 32 cycles.
- Signed -7 * 3 (a=0xFFFFFFF9, b=3, both signed) -> lo=0xFFFFFFEB, hi=0xFFFFFFFF. Same operands with both flags 0 -> lo=0xFFFFFFEB, hi=0x00000002.
- Corners:
  - 0xFFFFFFFF*0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
  - Same operands signed -> hi=0, lo=1.
  - 0x80000000*0x80000000 signed -> hi=0x40000000, lo=0.
- MULHSU: a=0xFFFFFFFF signed, b=0xFFFFFFFF unsigned -> hi=0xFFFFFFFF, lo=0x00000001. Also -5 * 0 -> hi=0, lo=0.
- Protocol:
  - i_valid pulsed again mid-CALC with new operands -> ignored; the first result is returned on schedule.
  - i_valid in the first DONE cycle -> o_valid drops, and the second result arrives 32 cycles later.
- Reset asserted at CALC count 10 -> all outputs 0 immediately (async). After release, no o_valid until a new i_valid; a new 6*7 -> lo=42.
